// File: rtl/sigma_pkg.sv
// Shared definitions for the sigma scheduler and its sibling shared-FP-unit schedulers.
package sigma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_FLUSH
    } state_t;

    localparam logic [31:0] FP_ONE   = 32'h3f800000;
    localparam logic [31:0] FP_THREE = 32'h40400000;

    localparam int DEFAULT_TIMEOUT = 128;
    localparam int DEFAULT_DRAIN   = 128;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = ID_W'((int'(last) + i) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sigma_scheduler.sv
// Time-shares one non-reentrant sigma datapath among NUM_REQ requesters, one job at a time,
// with a timeout on lost results and a drain interval so late results are never misattributed.
module sigma_scheduler
    import sigma_pkg::*;
#(
    parameter int PRECISION = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int TIMEOUT   = DEFAULT_TIMEOUT,
    parameter int DRAIN     = DEFAULT_DRAIN
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*PRECISION-1:0]   req_err,
    input  logic [NUM_REQ*9*PRECISION-1:0] req_a,
    output logic                           s_tvalid,
    output logic [PRECISION-1:0]           s_err,
    output logic [9*PRECISION-1:0]         s_a,
    input  logic                           s_valid,
    input  logic [PRECISION-1:0]           s_sigma,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [PRECISION-1:0]           rsp_sigma,
    output logic                           rsp_timeout,
    output logic                           busy,
    output logic [15:0]                    timeout_cnt
);

    localparam int CNT_W = 16;
    localparam int MAT_W = 9 * PRECISION;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [PRECISION-1:0] err_q, err_d;
    logic [MAT_W-1:0]     a_q, a_d;
    logic [PRECISION-1:0] sigma_q, sigma_d;
    logic                 to_q, to_d;
    logic [15:0]          tocnt_q, tocnt_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_id;
    logic                 arb_en;

    // Gating with reset keeps req_ready low for the whole reset pulse, not just after the edge.
    assign arb_en = (state_q == ST_IDLE) && !reset;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req    (req_valid),
        .last   (last_q),
        .en     (arb_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            id_q    <= '0;
            err_q   <= '0;
            a_q     <= '0;
            sigma_q <= '0;
            to_q    <= 1'b0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            a_q     <= a_d;
            sigma_q <= sigma_d;
            to_q    <= to_d;
            tocnt_q <= tocnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        id_d    = id_q;
        err_d   = err_q;
        a_d     = a_q;
        sigma_d = sigma_q;
        to_d    = to_q;
        tocnt_d = tocnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|(req_valid & gnt)) begin
                    err_d   = req_err[int'(gnt_id)*PRECISION +: PRECISION];
                    a_d     = req_a[int'(gnt_id)*MAT_W +: MAT_W];
                    id_d    = gnt_id;
                    last_d  = gnt_id;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_W'(TIMEOUT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (s_valid) begin
                    sigma_d = s_sigma;
                    to_d    = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == '0) begin
                    sigma_d = '0;
                    to_d    = 1'b1;
                    if (tocnt_q != 16'hFFFF) tocnt_d = tocnt_q + 16'd1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (to_q) begin
                        cnt_d   = CNT_W'(DRAIN - 1);
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready   = gnt;
    assign s_tvalid    = (state_q == ST_ISSUE);
    assign s_err       = err_q;
    assign s_a         = a_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_sigma   = sigma_q;
    assign rsp_timeout = to_q;
    assign busy        = (state_q != ST_IDLE);
    assign timeout_cnt = tocnt_q;

endmodule

// File: tb/tb_sigma_scheduler.sv
// Directed bench for sigma_scheduler with a fixed-latency stand-in for the sigma core.
module tb_sigma_scheduler;
    import sigma_pkg::*;

    localparam logic [31:0] FP_FOUR = 32'h40800000;
    localparam logic [287:0] IDENT = {FP_ONE, 32'h0, 32'h0, 32'h0, FP_ONE,
                                      32'h0, 32'h0, 32'h0, FP_ONE};

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [127:0]  req_err;
    logic [1151:0] req_a;
    logic          s_tvalid;
    logic [31:0]   s_err;
    logic [287:0]  s_a;
    logic          s_valid;
    logic [31:0]   s_sigma;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_id;
    logic [31:0]   rsp_sigma;
    logic          rsp_timeout;
    logic          busy;
    logic [15:0]   timeout_cnt;

    always #5 clk = ~clk;

    sigma_scheduler #(
        .PRECISION (32),
        .NUM_REQ   (4),
        .TIMEOUT   (16),
        .DRAIN     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_err     (req_err),
        .req_a       (req_a),
        .s_tvalid    (s_tvalid),
        .s_err       (s_err),
        .s_a         (s_a),
        .s_valid     (s_valid),
        .s_sigma     (s_sigma),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_sigma   (rsp_sigma),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .timeout_cnt (timeout_cnt)
    );

    // Sigma stand-in: result appears four cycles after the start pulse and reads err only at the end.
    logic [3:0]  lat_cnt;
    logic        mdl_valid;
    logic [31:0] mdl_sigma;
    logic        stray;
    logic        model_en;

    function automatic logic [31:0] sigma_model(input logic [287:0] a, input logic [31:0] e);
        if (a == IDENT) begin
            if (e == 32'h0)   return FP_THREE;
            if (e == FP_ONE)  return FP_FOUR;
            return 32'hBAD0BAD0;
        end
        return a[31:0] + a[159:128] + a[287:256] + e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt   <= 4'd0;
            mdl_valid <= 1'b0;
            mdl_sigma <= 32'h0;
        end else begin
            mdl_valid <= 1'b0;
            if (s_tvalid && model_en) begin
                lat_cnt <= 4'd4;
            end else if (lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) begin
                    mdl_valid <= 1'b1;
                    mdl_sigma <= sigma_model(s_a, s_err);
                end
            end
        end
    end

    assign s_valid = mdl_valid | stray;
    assign s_sigma = stray ? 32'hDEADBEEF : mdl_sigma;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rr(input int i);
        return 32'h300 * (i + 1) + 32'd12 + 32'h1000 * i;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},   req_ready, 4'b0000);
        check({tag, "_s_tvalid"},    s_tvalid, 1'b0);
        check({tag, "_s_err"},       s_err, 32'h0);
        check({tag, "_s_a_zero"},    s_a == '0, 1'b1);
        check({tag, "_rsp_valid"},   rsp_valid, 1'b0);
        check({tag, "_rsp_id"},      rsp_id, 2'd0);
        check({tag, "_rsp_sigma"},   rsp_sigma, 32'h0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        check({tag, "_busy"},        busy, 1'b0);
        check({tag, "_timeout_cnt"}, timeout_cnt, 16'h0);
    endtask

    // Full job from grant to response; handshakes the response only when rsp_ready is already high.
    task automatic run_job(input logic [3:0] vld, input int exp_id, input logic [31:0] exp_sig,
                           input logic exp_to, input bit keep, output int lat);
        int w, tv, leak, idle;
        logic [3:0] onehot;
        onehot    = 4'b0001 << exp_id;
        req_valid = vld;
        #1;
        w = 0;
        while (req_ready == 4'b0000 && w < 50) begin
            tick();
            w++;
        end
        check("grant_onehot", req_ready, onehot);
        check("grant_delay", w, 0);
        tick();
        if (!keep) req_valid = 4'b0000;
        lat = 0; tv = 0; leak = 0; idle = 0;
        while (!rsp_valid && lat < 300) begin
            if (s_tvalid) tv++;
            if (req_ready != 4'b0000) leak++;
            if (!busy) idle++;
            tick();
            lat++;
        end
        check("tvalid_pulses", tv, 1);
        check("ready_in_flight", leak, 0);
        check("busy_in_flight", idle, 0);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_id", rsp_id, exp_id);
        check("rsp_sigma", rsp_sigma, exp_sig);
        check("rsp_timeout", rsp_timeout, exp_to);
        if (rsp_ready) tick();
    endtask

    typedef struct {
        logic [3:0]  vld;
        int          id;
        logic [31:0] sigma;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int lat, n, bad, changes;
        logic [31:0] held;

        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        stray     = 1'b0;
        model_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_err[i*32 +: 32] = 32'h1000 * i;
            for (int k = 0; k < 9; k++) req_a[(i*9 + k)*32 +: 32] = 32'h100 * (i + 1) + k;
        end

        tbl[0] = '{4'b1111, 0, 32'h0};
        tbl[1] = '{4'b1111, 1, 32'h0};
        tbl[2] = '{4'b0101, 2, 32'h0};
        tbl[3] = '{4'b0101, 0, 32'h0};
        tbl[4] = '{4'b1000, 3, 32'h0};
        tbl[5] = '{4'b1000, 3, 32'h0};
        tbl[6] = '{4'b0011, 0, 32'h0};
        tbl[7] = '{4'b0110, 1, 32'h0};
        tbl[8] = '{4'b0001, 0, 32'h0};
        tbl[9] = '{4'b1110, 1, 32'h0};
        for (int i = 0; i < 10; i++) tbl[i].sigma = exp_rr(tbl[i].id);

        repeat (3) tick();
        check_reset_values("reset");
        reset     = 1'b0;
        req_valid = 4'b0000;
        tick();

        stray = 1'b1;
        tick();
        stray = 1'b0;
        check("stray_idle_rsp_valid", rsp_valid, 1'b0);
        check("stray_idle_busy", busy, 1'b0);

        for (int j = 0; j < 8; j++) run_job(4'b1111, j % 4, exp_rr(j % 4), 1'b0, 1'b1, lat);
        req_valid = 4'b0000;

        for (int i = 0; i < 10; i++) begin
            run_job(tbl[i].vld, tbl[i].id, tbl[i].sigma, 1'b0, 1'b0, lat);
            req_valid = 4'b0000;
        end

        req_a[2*288 +: 288]  = IDENT;
        req_err[2*32 +: 32]  = 32'h0;
        run_job(4'b0100, 2, FP_THREE, 1'b0, 1'b0, lat);
        check("ident_latency", lat, 6);

        req_err[2*32 +: 32] = FP_ONE;
        req_valid = 4'b0100;
        #1;
        check("errhold_grant", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000;
        req_err[2*32 +: 32] = 32'h0;
        held = s_err;
        check("errhold_captured", held, FP_ONE);
        n = 0; changes = 0;
        while (!rsp_valid && n < 300) begin
            if (s_err !== held) changes++;
            tick();
            n++;
        end
        check("errhold_changes", changes, 0);
        check("errhold_rsp_valid", rsp_valid, 1'b1);
        check("errhold_sigma", rsp_sigma, FP_FOUR);
        tick();

        rsp_ready = 1'b0;
        run_job(4'b1111, 3, exp_rr(3), 1'b0, 1'b1, lat);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sigma !== exp_rr(3) ||
                rsp_timeout !== 1'b0 || req_ready !== 4'b0000 || s_tvalid !== 1'b0) bad++;
        end
        check("bp_stable_cycles_bad", bad, 0);
        rsp_ready = 1'b1;
        tick();
        check("bp_next_grant", req_ready, 4'b0001);
        run_job(4'b1111, 0, exp_rr(0), 1'b0, 1'b0, lat);
        req_valid = 4'b0000;

        model_en = 1'b0;
        run_job(4'b0010, 1, 32'h0, 1'b1, 1'b0, lat);
        check("timeout_latency", lat, 17);
        check("timeout_cnt", timeout_cnt, 16'd1);
        model_en  = 1'b1;
        req_valid = 4'b0100;
        n = 0; bad = 0;
        while (busy && n < 50) begin
            stray = (n == 2);
            if (req_ready != 4'b0000 || rsp_valid) bad++;
            tick();
            n++;
        end
        stray = 1'b0;
        check("flush_cycles", n, 8);
        check("flush_quiet", bad, 0);
        run_job(4'b0100, 2, FP_THREE, 1'b0, 1'b0, lat);
        check("after_flush_timeout_cnt", timeout_cnt, 16'd1);
        req_valid = 4'b0000;

        req_valid = 4'b0010;
        #1;
        check("rstmid_grant", req_ready, 4'b0010);
        tick();
        check("rstmid_tvalid", s_tvalid, 1'b1);
        repeat (5) tick();
        check("rstmid_in_wait", busy, 1'b1);
        reset = 1'b1;
        #1;
        check_reset_values("rstmid");
        tick();
        tick();
        reset     = 1'b0;
        req_valid = 4'b0000;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid || busy) bad++;
        end
        check("rstmid_no_response", bad, 0);
        run_job(4'b1111, 0, exp_rr(0), 1'b0, 1'b0, lat);
        req_valid = 4'b0000;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
